// File: rtl/sram_pkg.sv
// Shared definitions for the async SRAM bus controller and its future users.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W = 19;
    localparam int unsigned SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } sram_state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Initiator for the board's async SRAM bus: converts single-word req/ready
// transactions into SETUP / ACCESS / HOLD strobe sequences. Every output is
// registered; the chip top builds the DAT tristate from DAT_OUT/DAT_OE.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W      = SRAM_ADDR_W,
    parameter int unsigned DATA_W      = SRAM_DATA_W,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [ADDR_W-1:0] ADR,
    output logic [DATA_W-1:0] DAT_OUT,
    output logic              DAT_OE,
    input  logic [DATA_W-1:0] DAT_IN,
    output logic              RAMCS,
    output logic              RAMOE,
    output logic              RAMWE
);

    localparam int unsigned       CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    sram_state_t       r_state, w_state;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_op_we, w_op_we;
    logic              r_ready, w_ready;
    logic [DATA_W-1:0] r_rdata, w_rdata;
    logic              r_rvalid, w_rvalid;
    logic [ADDR_W-1:0] r_adr, w_adr;
    logic [DATA_W-1:0] r_dat_out, w_dat_out;
    logic              r_dat_oe, w_dat_oe;
    logic              r_cs, w_cs;
    logic              r_oe, w_oe;
    logic              r_we, w_we;

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so that every pin comes straight from a flop.
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_op_we   = r_op_we;
        w_ready   = r_ready;
        w_rdata   = r_rdata;
        w_rvalid  = 1'b0;
        w_adr     = r_adr;
        w_dat_out = r_dat_out;
        w_dat_oe  = r_dat_oe;
        w_cs      = r_cs;
        w_oe      = r_oe;
        w_we      = r_we;

        unique case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_state  = ST_SETUP;
                    w_ready  = 1'b0;
                    w_op_we  = we;
                    w_adr    = addr;
                    w_cs     = 1'b0;
                    if (we) begin
                        w_dat_out = wdata;
                        w_dat_oe  = 1'b1;
                    end else begin
                        w_oe = 1'b0;
                    end
                end
            end
            ST_SETUP: begin
                w_state = ST_ACCESS;
                w_cnt   = CNT_LOAD;
                if (r_op_we) begin
                    w_we = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == '0) begin
                    // Strobes rise here; CS, ADR and write data stay for HOLD.
                    w_state = ST_HOLD;
                    w_we    = 1'b1;
                    w_oe    = 1'b1;
                    if (!r_op_we) begin
                        w_rdata  = DAT_IN;
                        w_rvalid = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                w_state  = ST_IDLE;
                w_cs     = 1'b1;
                w_dat_oe = 1'b0;
                w_ready  = 1'b1;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset to the bus idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_op_we   <= 1'b0;
            r_ready   <= 1'b1;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_adr     <= '0;
            r_dat_out <= '0;
            r_dat_oe  <= 1'b0;
            r_cs      <= 1'b1;
            r_oe      <= 1'b1;
            r_we      <= 1'b1;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_op_we   <= w_op_we;
            r_ready   <= w_ready;
            r_rdata   <= w_rdata;
            r_rvalid  <= w_rvalid;
            r_adr     <= w_adr;
            r_dat_out <= w_dat_out;
            r_dat_oe  <= w_dat_oe;
            r_cs      <= w_cs;
            r_oe      <= w_oe;
            r_we      <= w_we;
        end
    end

    assign ready   = r_ready;
    assign rdata   = r_rdata;
    assign rvalid  = r_rvalid;
    assign ADR     = r_adr;
    assign DAT_OUT = r_dat_out;
    assign DAT_OE  = r_dat_oe;
    assign RAMCS   = r_cs;
    assign RAMOE   = r_oe;
    assign RAMWE   = r_we;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three controller builds (WAIT_CYCLES 2, 1, 5), each
// with its own async SRAM model, a transaction-level reference model and a
// read-data scoreboard.
module tb_sram_ctrl;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    int unsigned n_vec  = 0;
    int unsigned n_err  = 0;
    int unsigned n_done = 0;

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int w,
                                input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (W=%0d) t=%0t actual=%h expected=%h", nm, w, $time, act, exp);
        end
    endfunction

    // Contents of a never-written SRAM word.
    function automatic logic [15:0] dflt(input logic [18:0] a);
        return a[15:0] ^ 16'h5A3C ^ {13'd0, a[18:16]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int W = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

        logic        rst = 1'b1;
        logic        req = 1'b0;
        logic        we_i = 1'b0;
        logic [18:0] addr = '0;
        logic [15:0] wdata = '0;
        logic        ready, rvalid, DAT_OE, RAMCS, RAMOE, RAMWE;
        logic [15:0] rdata, DAT_OUT;
        logic [15:0] DAT_IN = '0;
        logic [18:0] ADR;

        sram_ctrl #(.ADDR_W(19), .DATA_W(16), .WAIT_CYCLES(W)) dut (
            .clk(clk), .rst(rst), .req(req), .we(we_i), .addr(addr), .wdata(wdata),
            .ready(ready), .rdata(rdata), .rvalid(rvalid), .ADR(ADR),
            .DAT_OUT(DAT_OUT), .DAT_OE(DAT_OE), .DAT_IN(DAT_IN),
            .RAMCS(RAMCS), .RAMOE(RAMOE), .RAMWE(RAMWE)
        );

        // Reference model state: one transaction lives for W+3 cycles from accept.
        int          cyc = 0;
        int          a = -1000;
        int          dut_a = -1000;
        bit          in_flight = 1'b0;
        bit          op_we = 1'b0;
        bit          model_ok = 1'b0;
        logic [18:0] op_adr = '0;
        logic [15:0] op_dat = '0;
        logic [18:0] exp_adr = '0;
        logic [15:0] exp_dout = '0;
        logic [15:0] last_rdata = '0;
        int unsigned acc_cnt = 0;
        logic [15:0] ref_mem [int unsigned];
        logic [15:0] sram [int unsigned];
        exp_t        sb [$];
        logic        prev_we = 1'b1;

        // Transaction-level model, advanced on every rising edge.
        initial forever begin
            bit ready_m;
            @(posedge clk);
            cyc++;
            if (!rst && req && ready) dut_a = cyc;
            if (rst) begin
                in_flight  = 1'b0;
                sb.delete();
                exp_adr    = '0;
                exp_dout   = '0;
                last_rdata = '0;
                model_ok   = 1'b1;
            end else begin
                ready_m = !(in_flight && (cyc - a) <= W + 2);
                if (in_flight && op_we && (cyc - a) == W + 1)
                    ref_mem[32'(op_adr)] = op_dat;
                if (ready_m && req) begin
                    a         = cyc;
                    in_flight = 1'b1;
                    op_we     = we_i;
                    op_adr    = addr;
                    op_dat    = wdata;
                    exp_adr   = addr;
                    acc_cnt++;
                    if (we_i) exp_dout = wdata;
                    else sb.push_back('{data: ref_mem.exists(32'(addr)) ? ref_mem[32'(addr)] : dflt(addr),
                                        cyc: a + W + 1});
                end
            end
        end

        // SRAM pad model plus per-cycle output checks and the rdata scoreboard.
        initial forever begin
            int k;
            bit busy;
            exp_t it;
            @(negedge clk);
            if (RAMCS === 1'b0 && RAMWE === 1'b1 && prev_we === 1'b0)
                sram[32'(ADR)] = DAT_OUT;
            prev_we = RAMWE;
            if (RAMCS === 1'b0 && RAMOE === 1'b0)
                DAT_IN = sram.exists(32'(ADR)) ? sram[32'(ADR)] : dflt(ADR);
            else
                DAT_IN = 16'($urandom);
            if (model_ok) begin
                k    = cyc - a;
                busy = in_flight && (k <= W + 1);
                chk("ready",   W, 32'(ready),  32'(!busy));
                chk("RAMCS",   W, 32'(RAMCS),  32'(!busy));
                chk("RAMWE",   W, 32'(RAMWE),  32'(!(busy && op_we && k >= 1 && k <= W)));
                chk("RAMOE",   W, 32'(RAMOE),  32'(!(busy && !op_we && k <= W)));
                chk("DAT_OE",  W, 32'(DAT_OE), 32'(busy && op_we));
                chk("rvalid",  W, 32'(rvalid), 32'(busy && !op_we && k == W + 1));
                chk("ADR",     W, 32'(ADR),    32'(exp_adr));
                chk("DAT_OUT", W, 32'(DAT_OUT), 32'(exp_dout));
                chk("inv_we_oe", W, 32'(RAMWE === 1'b0 && RAMOE === 1'b0), 32'(0));
                chk("inv_oe_drive", W, 32'(DAT_OE === 1'b1 && RAMOE === 1'b0), 32'(0));
                chk("inv_strobe_cs", W, 32'((RAMWE === 1'b0 || RAMOE === 1'b0) && RAMCS !== 1'b0), 32'(0));
                if (rvalid === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("rvalid_unexpected", W, 32'(rvalid), 32'(0));
                    end else begin
                        it = sb.pop_front();
                        chk("rvalid_cycle", W, 32'(cyc), 32'(it.cyc));
                        chk("rdata", W, 32'(rdata), 32'(it.data));
                        last_rdata = it.data;
                    end
                end else begin
                    chk("rdata_hold", W, 32'(rdata), 32'(last_rdata));
                end
            end
        end

        // Called at a falling edge; returns at the falling edge after accept.
        task automatic issue(input bit w, input logic [18:0] ad, input logic [15:0] d);
            int unsigned c0;
            c0    = acc_cnt;
            we_i  = w;
            addr  = ad;
            wdata = d;
            req   = 1'b1;
            for (int i = 0; i < 60; i++) begin
                @(posedge clk);
                #1;
                if (acc_cnt != c0) break;
            end
            if (acc_cnt == c0) chk("accept_timeout", W, 32'(acc_cnt), 32'(c0 + 1));
            @(negedge clk);
            req   = 1'b0;
            we_i  = 1'($urandom);
            addr  = 19'($urandom);
            wdata = 16'($urandom);
        endtask

        // Stimulus: directed cases then randomized traffic.
        initial begin
            int prev;
            int unsigned c0;
            logic [18:0] ra;
            rst = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;

            issue(1'b1, 19'h12345, 16'hBEEF);
            issue(1'b0, 19'h12345, 16'h0000);
            issue(1'b1, 19'h7FFFF, 16'hA55A);
            issue(1'b0, 19'h7FFFF, 16'h0000);
            issue(1'b0, 19'h00000, 16'h0000);

            // req held high: alternating write/read over 8 addresses.
            prev = -1;
            req  = 1'b1;
            for (int i = 0; i < 16; i++) begin
                we_i  = (i % 2) == 0;
                addr  = 19'(32'h00100 + 32'(i / 2));
                wdata = 16'($urandom);
                c0    = acc_cnt;
                for (int j = 0; j < 60; j++) begin
                    @(posedge clk);
                    #1;
                    if (acc_cnt != c0) break;
                end
                if (acc_cnt == c0) chk("accept_timeout", W, 32'(acc_cnt), 32'(c0 + 1));
                if (prev >= 0) chk("accept_gap", W, 32'(dut_a - prev), 32'(W + 3));
                prev = dut_a;
            end
            @(negedge clk);
            req = 1'b0;

            // Reset lands in the ACCESS phase of a write; then normal traffic.
            issue(1'b1, 19'h00AAA, 16'h1234);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            issue(1'b0, 19'h00AAA, 16'h0000);
            issue(1'b1, 19'h00AAB, 16'h4321);
            issue(1'b0, 19'h00AAB, 16'h0000);

            for (int i = 0; i < 30; i++) begin
                ra = ($urandom_range(0, 3) == 0) ? 19'($urandom) : 19'(32'h00100 + $urandom_range(0, 7));
                issue(1'($urandom), ra, 16'($urandom));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end

            repeat (W + 6) @(negedge clk);
            chk("sb_drain", W, 32'(sb.size()), 32'(0));
            n_done++;
        end
    end

    initial begin
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (n_done == 3) break;
        end
        if (n_done != 3) chk("global_timeout", 0, 32'(n_done), 32'(3));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
